// File: rtl/ws2812_frame_tx.sv
// WS2812 frame transmitter: reads LED_CNT GRB words from a synchronous-read bank,
// sends each MSB first as pulse-width bits, then holds the line low for the latch.
// Optional per-channel brightness scaling: define LEDTX_BRIGHTNESS_EN.
module ws2812_frame_tx #(
  parameter int LED_CNT = 11,
  parameter int ADDR_W  = 4,
  parameter int T0H     = 4,
  parameter int T1H     = 8,
  parameter int TBIT    = 12,
  parameter int TRESET  = 600
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
`ifdef LEDTX_BRIGHTNESS_EN
  input  logic [2:0]        brightness_i,
`endif
  output logic [ADDR_W-1:0] rd_addr_o,
  input  logic [23:0]       rd_data_i,
  output logic              led_o,
  output logic              busy_o,
  output logic              frame_done_o
);

  // One counter serves both the bit period and the latch, so size it for the larger.
  localparam int CNT_MAX = (TRESET > TBIT) ? TRESET : TBIT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]  T0H_C    = CNT_W'(T0H);
  localparam logic [CNT_W-1:0]  T1H_C    = CNT_W'(T1H);
  localparam logic [CNT_W-1:0]  TBIT_END = CNT_W'(TBIT - 1);
  localparam logic [CNT_W-1:0]  TRST_END = CNT_W'(TRESET - 1);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(LED_CNT - 1);

  typedef enum logic [2:0] {IDLE, ADDR, CAPT, SEND, LATCH} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [4:0]          bit_q, bit_d;
  logic [23:0]         shift_q, shift_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic                led_q, led_d;
  logic                done_q, done_d;
  logic                from_send_q, from_send_d;
  logic [23:0]         word_in;

`ifdef LEDTX_BRIGHTNESS_EN
  assign word_in = {rd_data_i[23:16] >> brightness_i,
                    rd_data_i[15:8]  >> brightness_i,
                    rd_data_i[7:0]   >> brightness_i};
`else
  assign word_in = rd_data_i;
`endif

  // Reset lands in LATCH so the strip always sees a full latch after power-up or a glitch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= LATCH;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      idx_q       <= '0;
      led_q       <= 1'b0;
      done_q      <= 1'b0;
      from_send_q <= 1'b0;
    end else begin
      // NOTE: non-blocking here so every register samples pre-edge values of the others.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      idx_q       <= idx_d;
      led_q       <= led_d;
      done_q      <= done_d;
      from_send_q <= from_send_d;
    end
  end

  always_comb begin
    // NOTE: every target gets a default first, otherwise unassigned paths infer latches.
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    idx_d       = idx_q;
    led_d       = 1'b0;
    done_d      = 1'b0;
    from_send_d = from_send_q;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = ADDR;
          idx_d   = '0;
        end
      end
      ADDR: state_d = CAPT;
      CAPT: begin
        shift_d = word_in;
        bit_d   = 5'd23;
        cnt_d   = '0;
        state_d = SEND;
      end
      SEND: begin
        led_d = (cnt_q < (shift_q[23] ? T1H_C : T0H_C));
        if (cnt_q == TBIT_END) begin
          cnt_d = '0;
          if (bit_q != 5'd0) begin
            shift_d = shift_q << 1;
            bit_d   = bit_q - 5'd1;
          end else if (idx_q == LAST_IDX) begin
            state_d     = LATCH;
            from_send_d = 1'b1;
          end else begin
            idx_d   = idx_q + ADDR_W'(1);
            state_d = ADDR;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      LATCH: begin
        if (cnt_q == TRST_END) begin
          state_d     = IDLE;
          done_d      = from_send_q;
          from_send_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = LATCH;
    endcase
  end

  assign rd_addr_o    = idx_q;
  assign led_o        = led_q;
  assign busy_o       = (state_q != IDLE);
  assign frame_done_o = done_q;

endmodule

// File: tb/tb_ws2812_frame_tx.sv
// Bench for ws2812_frame_tx: a per-cycle waveform model built from the bank contents,
// checked every cycle, plus literal pulse-width, address and timing expectations.
module tb_ws2812_frame_tx;

  localparam int LED_CNT   = 2;
  localparam int ADDR_W    = 4;
  localparam int T0H       = 2;
  localparam int T1H       = 4;
  localparam int TBIT      = 6;
  localparam int TRESET    = 10;
  localparam int LED_CYC   = 2 + 24 * TBIT;
  localparam int FRAME_CYC = LED_CNT * LED_CYC;
  localparam int DONE_AT   = FRAME_CYC + TRESET + 1;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start_i = 1'b0;
  logic [ADDR_W-1:0] rd_addr_o;
  logic [23:0]       rd_data_i;
  logic              led_o, busy_o, frame_done_o;
`ifdef LEDTX_BRIGHTNESS_EN
  logic [2:0]        brightness_i = 3'd0;
`endif

  logic [23:0] bank [0:(1<<ADDR_W)-1];

  always #5 clk = ~clk;
  always @(posedge clk) rd_data_i <= bank[rd_addr_o];

  ws2812_frame_tx #(
    .LED_CNT(LED_CNT), .ADDR_W(ADDR_W), .T0H(T0H), .T1H(T1H), .TBIT(TBIT), .TRESET(TRESET)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start_i      (start_i),
`ifdef LEDTX_BRIGHTNESS_EN
    .brightness_i (brightness_i),
`endif
    .rd_addr_o    (rd_addr_o),
    .rd_data_i    (rd_data_i),
    .led_o        (led_o),
    .busy_o       (busy_o),
    .frame_done_o (frame_done_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    bit care;
    bit led;
    bit busy;
    bit done;
    int addr;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        cur;
  int          idle_addr  = 0;
  int          cur_bright = 0;
  logic [23:0] last_word0 = '0;

  function automatic logic [23:0] tx_word(input logic [23:0] w, input int b);
    logic [7:0] g, r, bl;
    g  = w[23:16] >> b;
    r  = w[15:8]  >> b;
    bl = w[7:0]   >> b;
    return {g, r, bl};
  endfunction

  // Expected outputs for the start cycle and every cycle up to the done pulse.
  task automatic push_frame();
    bit          w[$];
    logic [23:0] word;
    int          hi;
    exp_q.push_back('{care: 1'b1, led: 1'b0, busy: 1'b0, done: 1'b0, addr: idle_addr});
    w.push_back(1'b0);
    for (int i = 0; i < LED_CNT; i++) begin
      word = tx_word(bank[i], cur_bright);
      w.push_back(1'b0);
      w.push_back(1'b0);
      for (int b = 23; b >= 0; b--) begin
        hi = word[b] ? T1H : T0H;
        for (int c = 0; c < TBIT; c++) w.push_back(c < hi);
      end
    end
    for (int j = 1; j <= DONE_AT; j++) begin
      exp_q.push_back('{care: 1'b1,
                        led:  (j - 1 < w.size()) ? w[j-1] : 1'b0,
                        busy: (j < DONE_AT),
                        done: (j == DONE_AT),
                        addr: (j <= FRAME_CYC) ? (j - 1) / LED_CYC : LED_CNT - 1});
    end
    idle_addr = LED_CNT - 1;
  endtask

  // Called just after an edge: the current cycle keeps its expectation, then a full latch.
  task automatic apply_reset_now();
    exp_t first;
    reset = 1'b1;
    if (exp_q.size() > 0) begin
      first = exp_q[0];
      exp_q.delete();
      exp_q.push_back(first);
    end else begin
      exp_q.push_back('{care: 1'b0, led: 1'b0, busy: 1'b0, done: 1'b0, addr: 0});
    end
    for (int k = 0; k < TRESET; k++)
      exp_q.push_back('{care: 1'b1, led: 1'b0, busy: 1'b1, done: 1'b0, addr: 0});
    idle_addr = 0;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) cur = exp_q.pop_front();
    else cur = '{care: 1'b1, led: 1'b0, busy: 1'b0, done: 1'b0, addr: idle_addr};
    if (cur.care) begin
      check("led_o", 32'(led_o), 32'(cur.led));
      check("busy_o", 32'(busy_o), 32'(cur.busy));
      check("frame_done_o", 32'(frame_done_o), 32'(cur.done));
      check("rd_addr_o", 32'(rd_addr_o), 32'(cur.addr));
    end
  end

  // Starts a frame in the current cycle; p1/p2 are extra start pulses, rst_at a reset cycle.
  task automatic run_frame(input int p1, input int p2, input int rst_at, input bit chk_w);
    int widths[$];
    int rise[$];
    int done_j = -1;
    int n_done = 0;
    int run    = 0;
    int last;
    int lit0[8] = '{4, 2, 4, 2, 2, 4, 2, 4};
    push_frame();
    start_i = 1'b1;
    last = (rst_at > 0) ? rst_at + TRESET + 3 : DONE_AT + 3;
    for (int j = 1; j <= last; j++) begin
      @(posedge clk);
      #1;
      start_i = (j == p1) || (j == p2);
      if (j == rst_at) apply_reset_now();
      if (rst_at > 0 && j == rst_at + 1) reset = 1'b0;
      if (frame_done_o) begin
        n_done++;
        if (done_j < 0) done_j = j;
        check("busy_at_done", 32'(busy_o), 32'd0);
      end
      if (led_o) begin
        if (run == 0) rise.push_back(j);
        run++;
      end else if (run > 0) begin
        widths.push_back(run);
        run = 0;
      end
      if (rst_at == 0 && j == 1) check("addr_led0", 32'(rd_addr_o), 32'd0);
      if (rst_at == 0 && j == LED_CYC + 1) check("addr_led1", 32'(rd_addr_o), 32'd1);
    end
    if (widths.size() >= 24) begin
      last_word0 = '0;
      for (int k = 0; k < 24; k++) last_word0[23-k] = (widths[k] == T1H);
    end
    if (rst_at > 0) begin
      check("done_after_reset", 32'(n_done), 32'd0);
    end else begin
      check("done_cycle", 32'(done_j), 32'd303);
      check("done_count", 32'(n_done), 32'd1);
      if (chk_w) begin
        check("pulse_count", 32'(widths.size()), 32'd48);
        for (int k = 0; k < 48 && k < widths.size(); k++)
          check("pulse_width", 32'(widths[k]), (k < 8) ? 32'(lit0[k]) : ((k == 47) ? 32'd4 : 32'd2));
        if (rise.size() >= 25) begin
          check("bit_period", 32'(rise[1] - rise[0]), 32'd6);
          check("led_gap_period", 32'(rise[24] - rise[23]), 32'd8);
        end
      end
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int n;
    for (int i = 0; i < (1 << ADDR_W); i++) bank[i] = '0;
    bank[0] = 24'hA50000;
    bank[1] = 24'h000001;

    @(posedge clk);
    #1;
    apply_reset_now();
    @(posedge clk);
    #1;
    reset = 1'b0;
    n = 0;
    while (busy_o && n < 20) begin
      n++;
      @(posedge clk);
      #1;
    end
    check("post_reset_busy_len", 32'(n), 32'd10);
    idle_cycles(3);

    run_frame(0, 0, 0, 1'b1);
    check("word0_bits", 32'(last_word0), 32'hA50000);
    idle_cycles(4);

    run_frame(50, 200, 0, 1'b1);
    idle_cycles(12);

    run_frame(0, 0, 35, 1'b0);
    idle_cycles(5);
    run_frame(0, 0, 0, 1'b1);
    idle_cycles(3);

`ifdef LEDTX_BRIGHTNESS_EN
    bank[0]      = 24'hFF80FF;
    brightness_i = 3'd3;
    cur_bright   = 3;
    run_frame(0, 0, 0, 1'b0);
    check("bright3_word0", 32'(last_word0), 32'h1F101F);
    idle_cycles(3);
    brightness_i = 3'd0;
    cur_bright   = 0;
    run_frame(0, 0, 0, 1'b0);
    check("bright0_word0", 32'(last_word0), 32'hFF80FF);
    idle_cycles(3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ws2812_frame_tx.md
Name: ws2812_frame_tx

Overview:
- Downstream stage of the I2C LED register file: streams LED_CNT stored 24-bit GRB colour words onto a single WS2812-compatible serial line.
- On a start pulse it reads each word through a synchronous-read port, serialises it MSB first with pulse-width bit encoding, then holds the line low for the latch/reset time.
- Sits between the LED colour register bank and the led_o pad.

Parameters:
- LED_CNT, 11, number of LEDs (words) per frame; legal range 1..2^ADDR_W.
- ADDR_W, 4, width of rd_addr_o.
- T0H, 4, clk cycles led_o is high for a '0' bit.
- T1H, 8, clk cycles led_o is high for a '1' bit.
- TBIT, 12, total clk cycles per bit; T0H < T1H < TBIT.
- TRESET, 600, clk cycles of low level for the latch; at least 50 us at the target clock.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- start_i  input  1  frame request; sampled only in IDLE.
- rd_addr_o  output  ADDR_W  word index into the LED register bank.
- rd_data_i  input  24  word at rd_addr_o, valid one cycle after the address is presented; [23:16]=G, [15:8]=R, [7:0]=B.
- led_o  output  1  serial data to the LED strip.
- busy_o  output  1  high whenever the FSM is not in IDLE.
- frame_done_o  output  1  one-cycle pulse at the end of a start-initiated frame's latch.

Behaviour:
- All state updates on the rising edge of clk. Reset is synchronous, active-high.
- Reset values: led_o=0, rd_addr_o=0, frame_done_o=0, busy_o=1, state=LATCH, latch counter=0. The strip is resynchronised after every reset.
- States: IDLE, ADDR, CAPT, SEND, LATCH.
- IDLE: led_o=0, busy_o=0.
  - start_i=1 -> ADDR, with LED index=0.
- ADDR: rd_addr_o=index, held for 1 cycle -> CAPT.
- CAPT: shift register <= rd_data_i (rd_addr_o still = index); bit counter=23; cycle counter=0 -> SEND.
- SEND:
  - Each bit lasts exactly TBIT cycles, counter 0..TBIT-1.
  - led_o=1 while counter < (current bit ? T1H : T0H), else 0. led_o is registered, so the waveform is delayed one cycle relative to the counter.
  - At counter=TBIT-1: if bit counter>0, shift left and decrement.
  - Else, if index==LED_CNT-1 -> LATCH with counter=0. Otherwise index+1 -> ADDR.
  - Inter-LED gap: 2 extra low cycles (ADDR, CAPT). This is intentional and far below the latch threshold.
- LATCH: led_o=0 for exactly TRESET cycles, then -> IDLE.
  - frame_done_o pulses for 1 cycle on the LATCH->IDLE transition, only if LATCH was entered from SEND.
  - The post-reset latch produces no pulse.
- start_i while busy_o=1 is ignored; it is not queued.
- rd_data_i is ignored outside CAPT. A mid-frame change in the register bank affects only words not yet captured.
- Frame duration from start_i sample to frame_done_o: LED_CNT*(2+24*TBIT)+TRESET+1 cycles.
- Reset mid-frame: led_o=0 on the next edge; a full TRESET latch follows, so the partial frame is discarded by the strip.
- LED_CNT=1: ADDR/CAPT/SEND run once, then LATCH.
- Counter widths sized for TRESET; no wrap-around inside a state.

Optional Feature:
- Macro: LEDTX_BRIGHTNESS_EN.
- With the macro defined:
  - Adds input brightness_i, 3 bits.
  - In CAPT, each 8-bit channel of rd_data_i is logically right-shifted by brightness_i before loading. 0 = full brightness, 7 = each channel reduced to its MSB.
  - brightness_i is sampled only in CAPT.
- Without the macro: the port is absent and words are sent unmodified.

Test Plan:
- Use bench parameters LED_CNT=2, T0H=2, T1H=4, TBIT=6, TRESET=10 for all scenarios.
- Post-reset latch: assert reset 1 cycle -> busy_o=1 for 10 cycles, led_o=0 throughout, frame_done_o never pulses, then busy_o=0.
- Bit encoding:
  - Bank {0xA50000, 0x000001}, start_i pulse -> first LED's bits 1,0,1,0,0,1,0,1 give high widths 4,2,4,2,2,4,2,4 cycles, each bit period 6 cycles.
  - Last LED: 23 pulses of width 2, then 1 pulse of width 4.
  - rd_addr_o sequence 0,1.
- Frame timing: same start -> frame_done_o exactly 2*(2+144)+10+1=303 cycles after the start_i sample edge; busy_o falls the same cycle.
- Start while busy: pulse start_i at cycles 50 and 200 of a frame -> exactly one frame is sent, and rd_addr_o does not return to 0 until the next IDLE start.
- Reset mid-frame: assert reset during LED 0 bit 5 -> led_o=0 next cycle, 10-cycle latch, no frame_done_o; a following start sends a complete frame from index 0.
- LEDTX_BRIGHTNESS_EN: word 0xFF80FF with brightness_i=3 -> transmitted bits equal 0x1F101F; with brightness_i=0 -> 0xFF80FF.
